// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that merges NREQ valid/ready requesters
// into one registered write port of a downstream FIFO, gated by credits.
//
// Ports:
//   clk         rising-edge clock
//   res         asynchronous active-low reset
//   req_valid   per-requester valid            [NREQ]
//   req_data    requester i at [i*WIDTH +: WIDTH]
//   req_ready   per-requester accept (comb. from registered state)
//   fifo_wr_en  registered FIFO write strobe
//   fifo_wdata  registered FIFO write data     [WIDTH]
//   fifo_rd_en  FIFO read strobe (credit return when not empty)
//   fifo_empty  FIFO empty flag
//   grant_id    current owner, 0 when idle
//   credits     free FIFO slots tracked locally
module fifo_wr_arb #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int FIFO_SIZE = 16,
    parameter int BURST     = 4,
    // An index needs at least one bit, even with a single requester.
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW = $clog2(FIFO_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_wr_en,
    output logic [WIDTH-1:0]      fifo_wdata,
    input  logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    output logic [IW-1:0]         grant_id,
    output logic [CW-1:0]         credits
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_last_owner;
    logic [BW-1:0]    r_beat;
    logic [CW-1:0]    r_credits;
    logic             r_wr_en;
    logic [WIDTH-1:0] r_wdata;

    logic [WIDTH-1:0] w_data [NREQ];
    logic [NREQ-1:0]  w_ready;
    logic [IW-1:0]    w_pick;
    logic [IW-1:0]    w_cand;
    logic             w_found;
    logic             w_has_cr;
    logic             w_xfer;
    logic             w_ret;
    logic             w_last_beat;
    logic             w_release;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_data[g] = req_data[g*WIDTH +: WIDTH];
    end

    assign w_has_cr    = (r_credits != '0);
    assign w_ret       = fifo_rd_en && !fifo_empty;
    assign w_xfer      = (r_state == ST_GRANT)
                      && req_valid[r_owner] && w_has_cr;
    assign w_last_beat = (r_beat == BW'(BURST - 1));

    // A credit arriving in the same cycle keeps a starved owner alive.
    assign w_release = !req_valid[r_owner]
                    || (!w_has_cr && !w_ret)
                    || (w_xfer && w_last_beat);

    // Round-robin search starting just after the previous owner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = IW'((int'(r_last_owner) + 1 + i) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == ST_GRANT && w_has_cr) begin
            w_ready[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= IW'(NREQ - 1);
            r_beat       <= '0;
            r_credits    <= CW'(FIFO_SIZE);
            r_wr_en      <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wdata <= w_data[r_owner];
            end

            // Simultaneous take and return cancel out.
            if (w_xfer && !w_ret) begin
                r_credits <= r_credits - CW'(1);
            end else if (w_ret && !w_xfer
                         && r_credits != CW'(FIFO_SIZE)) begin
                r_credits <= r_credits + CW'(1);
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_found && w_has_cr) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_pick;
                        r_beat  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer) begin
                        r_beat <= r_beat + BW'(1);
                    end
                    if (w_release) begin
                        r_state      <= ST_IDLE;
                        r_last_owner <= r_owner;
                        r_owner      <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign fifo_wr_en = r_wr_en;
    assign fifo_wdata = r_wdata;
    assign grant_id   = r_owner;
    assign credits    = r_credits;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: table vectors, directed corner sequences and a
// randomized run against a queue-free behavioural model of the arbiter.
module tb_fifo_wr_arb;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int FS = 16;
    localparam int B  = 4;

    logic           clk = 1'b0;
    logic           res = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wdata;
    logic           fifo_rd_en = 1'b0;
    logic           fifo_empty = 1'b1;
    logic [1:0]     grant_id;
    logic [4:0]     credits;

    int checks = 0;
    int errors = 0;

    fifo_wr_arb #(
        .WIDTH(W), .NREQ(N), .FIFO_SIZE(FS), .BURST(B)
    ) dut (
        .clk       (clk),
        .res       (res),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wdata(fifo_wdata),
        .fifo_rd_en(fifo_rd_en),
        .fifo_empty(fifo_empty),
        .grant_id  (grant_id),
        .credits   (credits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       rd;
        int         g;
        logic       wr;
        int         wd;
        int         rdy;
        int         cr;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b0;
        req_valid = '0;
        fifo_rd_en = 1'b0;
        fifo_empty = 1'b1;
        #1;
        chk("rst_wr", int'(fifo_wr_en), 0);
        chk("rst_wdata", int'(fifo_wdata), 0);
        chk("rst_grant", int'(grant_id), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_credits", int'(credits), FS);
        @(negedge clk);
        res = 1'b1;
    endtask

    // Behavioural model: owner (-1 = idle), beats taken, credit count.
    int           m_own;
    int           m_last;
    int           m_beats;
    int           m_cr;
    logic         m_wr;
    logic [W-1:0] m_wd;

    task automatic model_reset();
        m_own = -1;
        m_last = N - 1;
        m_beats = 0;
        m_cr = FS;
        m_wr = 1'b0;
        m_wd = '0;
    endtask

    task automatic model_step();
        bit ret;
        bit xfer;
        bit rel;
        bit found;
        int cr0;
        int c;
        ret = fifo_rd_en && !fifo_empty;
        xfer = (m_own >= 0) && req_valid[m_own] && (m_cr > 0);
        cr0 = m_cr;
        m_wr = xfer;
        if (xfer) m_wd = req_data[m_own*W +: W];
        m_cr = m_cr - int'(xfer) + int'(ret);
        if (m_cr > FS) m_cr = FS;
        if (m_own < 0) begin
            if (req_valid != 0 && cr0 > 0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && req_valid[c]) begin
                        found = 1;
                        m_own = c;
                    end
                end
                m_beats = 0;
            end
        end else begin
            rel = !req_valid[m_own] || (cr0 == 0 && !ret)
               || (xfer && m_beats + 1 == B);
            if (xfer) m_beats++;
            if (rel) begin
                m_last = m_own;
                m_own = -1;
            end
        end
    endtask

    function automatic vec_t mk(int g, logic wr, int wd, int rdy, int cr);
        vec_t r;
        r.v = 4'hF;
        r.rd = 1'b0;
        r.g = g;
        r.wr = wr;
        r.wd = wd;
        r.rdy = rdy;
        r.cr = cr;
        return r;
    endfunction

    initial begin
        int cnt;
        bit found;
        int exp_rdy;

        tbl[0]  = mk(0, 0, 'h00, 1, 16);
        tbl[1]  = mk(0, 1, 'hA0, 1, 15);
        tbl[2]  = mk(0, 1, 'hA0, 1, 14);
        tbl[3]  = mk(0, 1, 'hA0, 1, 13);
        tbl[4]  = mk(0, 1, 'hA0, 0, 12);
        tbl[5]  = mk(1, 0, 'hA0, 2, 12);
        tbl[6]  = mk(1, 1, 'hA1, 2, 11);
        tbl[7]  = mk(1, 1, 'hA1, 2, 10);
        tbl[8]  = mk(1, 1, 'hA1, 2, 9);
        tbl[9]  = mk(0, 1, 'hA1, 0, 8);
        tbl[10] = mk(2, 0, 'hA1, 4, 8);
        tbl[11] = mk(2, 1, 'hA2, 4, 7);
        tbl[12] = mk(2, 1, 'hA2, 4, 6);
        tbl[13] = mk(2, 1, 'hA2, 4, 5);
        tbl[14] = mk(0, 1, 'hA2, 0, 4);
        tbl[15] = mk(3, 0, 'hA2, 8, 4);
        tbl[16] = mk(3, 1, 'hA3, 8, 3);
        tbl[17] = mk(3, 1, 'hA3, 8, 2);
        tbl[18] = mk(3, 1, 'hA3, 8, 1);
        tbl[19] = mk(0, 1, 'hA3, 0, 0);
        tbl[20] = mk(0, 0, 'hA3, 0, 0);

        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Four requesters streaming: 0,1,2,3 bursts of 4.
        do_reset();
        cnt = 0;
        foreach (tbl[i]) begin
            req_valid = tbl[i].v;
            fifo_rd_en = tbl[i].rd;
            fifo_empty = !tbl[i].rd;
            tick();
            if (i < 20) cnt += int'(fifo_wr_en);
            chk($sformatf("tbl%0d_grant", i), int'(grant_id), tbl[i].g);
            chk($sformatf("tbl%0d_wr", i), int'(fifo_wr_en), int'(tbl[i].wr));
            chk($sformatf("tbl%0d_wdata", i), int'(fifo_wdata), tbl[i].wd);
            chk($sformatf("tbl%0d_ready", i), int'(req_ready), tbl[i].rdy);
            chk($sformatf("tbl%0d_credits", i), int'(credits), tbl[i].cr);
        end
        chk("tbl_pulses_20cyc", cnt, 16);

        // Single requester, no reads: credit exhaustion.
        do_reset();
        req_valid = 4'b0100;
        cnt = 0;
        repeat (40) begin
            tick();
            cnt += int'(fifo_wr_en);
        end
        chk("exhaust_pulses", cnt, 16);
        chk("exhaust_credits", int'(credits), 0);
        chk("exhaust_ready", int'(req_ready), 0);

        // One credit returned lets exactly one beat through.
        fifo_rd_en = 1'b1;
        fifo_empty = 1'b0;
        tick();
        chk("ret1_credits", int'(credits), 1);
        fifo_rd_en = 1'b0;
        fifo_empty = 1'b1;
        cnt = 0;
        repeat (10) begin
            tick();
            cnt += int'(fifo_wr_en);
        end
        chk("ret1_pulses", cnt, 1);
        chk("ret1_credits_end", int'(credits), 0);

        // Return on a full count is ignored.
        do_reset();
        fifo_rd_en = 1'b1;
        fifo_empty = 1'b0;
        tick();
        chk("ret_full_credits", int'(credits), FS);
        fifo_rd_en = 1'b0;
        fifo_empty = 1'b1;

        // Take and return together at credits 5.
        do_reset();
        req_valid = 4'b0001;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (req_ready[0] && credits == 5) begin
                found = 1;
                fifo_rd_en = 1'b1;
                fifo_empty = 1'b0;
                tick();
                chk("both_credits", int'(credits), 5);
                chk("both_wr", int'(fifo_wr_en), 1);
                fifo_rd_en = 1'b0;
                fifo_empty = 1'b1;
            end else begin
                tick();
            end
        end
        chk("both_reached", int'(found), 1);

        // Owner 1 drops valid after two beats.
        do_reset();
        req_valid = 4'b0110;
        tick();
        chk("drop_grant1", int'(grant_id), 1);
        cnt = 0;
        repeat (2) begin
            tick();
            cnt += int'(fifo_wr_en);
        end
        chk("drop_beats", cnt, 2);
        req_valid = 4'b0100;
        tick();
        chk("drop_idle_grant", int'(grant_id), 0);
        chk("drop_idle_ready", int'(req_ready), 0);
        chk("drop_idle_wr", int'(fifo_wr_en), 0);
        tick();
        chk("drop_next_grant", int'(grant_id), 2);

        // Reset pulse in the middle of a burst.
        do_reset();
        req_valid = 4'hF;
        repeat (7) tick();
        chk("midrst_pre_grant", int'(grant_id), 1);
        res = 1'b0;
        #1;
        chk("midrst_wr", int'(fifo_wr_en), 0);
        chk("midrst_wdata", int'(fifo_wdata), 0);
        chk("midrst_grant", int'(grant_id), 0);
        chk("midrst_ready", int'(req_ready), 0);
        chk("midrst_credits", int'(credits), FS);
        @(negedge clk);
        res = 1'b1;
        tick();
        chk("midrst_next_grant", int'(grant_id), 0);
        chk("midrst_next_ready", int'(req_ready), 1);

        // Randomized run against the model.
        do_reset();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < N; b++) begin
                req_valid[b] = ($urandom_range(0, 9) < 8);
            end
            req_data = $urandom;
            fifo_rd_en = $urandom_range(0, 1);
            fifo_empty = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            model_step();
            @(negedge clk);
            exp_rdy = (m_own >= 0 && m_cr > 0) ? (1 << m_own) : 0;
            chk("rnd_wr", int'(fifo_wr_en), int'(m_wr));
            chk("rnd_wdata", int'(fifo_wdata), int'(m_wd));
            chk("rnd_grant", int'(grant_id), (m_own < 0) ? 0 : m_own);
            chk("rnd_ready", int'(req_ready), exp_rdy);
            chk("rnd_credits", int'(credits), m_cr);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
